pipe_hazard_unit: RTL and testbench

- Parametrised hazard and forwarding controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Keeps its own registered shadow of the EX, MEM and WB stages, holding register addresses and control bits only.
- Generates load-use stalls, branch flushes and ALU operand forward selects.
- Replaces the purely combinational forwarding unit, which had no stall or flush capability.

---
 rtl/pipe_pkg.sv | 46 ++++
 rtl/fwd_select.sv | 37 +++
 rtl/pipe_hazard_unit.sv | 139 +++++++++++++
 tb/tb_pipe_hazard_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// SH_ADDR_W sizes the shadow address fields; the top-level ADDR_W must not exceed it.
package pipe_pkg;

  localparam int SH_ADDR_W = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef logic [SH_ADDR_W-1:0] sh_addr_t;

  typedef struct packed {
    logic     valid;
    sh_addr_t rs;
    sh_addr_t rt;
    sh_addr_t dst;
    logic     regwrite;
    logic     memread;
  } stage_sh_t;

  localparam stage_sh_t STAGE_CLR = '{
    valid:    1'b0,
    rs:       {SH_ADDR_W{1'b0}},
    rt:       {SH_ADDR_W{1'b0}},
    dst:      {SH_ADDR_W{1'b0}},
    regwrite: 1'b0,
    memread:  1'b0
  };

  // A stage can supply or create a hazard only if it really writes a non-hardwired register.
  function automatic logic is_src(input stage_sh_t s, input logic zero_reg);
    return s.valid & s.regwrite & ~(zero_reg & (s.dst == {SH_ADDR_W{1'b0}}));
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    logic [31:0] r;
    if (en && (v != 32'hFFFF_FFFF)) begin
      r = v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand forward selector: picks the youngest in-flight producer of one EX source register.
module fwd_select
  import pipe_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1,
  parameter bit WB_FWD   = 1'b1
) (
  input  logic      i_ex_valid,
  input  sh_addr_t  i_src,
  input  stage_sh_t i_mem,
  input  stage_sh_t i_wb,
  output logic [1:0] o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;
  logic w_unused;

  // A load in MEM has no result yet, so only non-load producers forward from EX/MEM.
  assign w_mem_hit = is_src(i_mem, ZERO_REG) & ~i_mem.memread & (i_mem.dst == i_src);
  assign w_wb_hit  = WB_FWD & is_src(i_wb, ZERO_REG) & (i_wb.dst == i_src);
  assign w_unused  = ^{i_mem.rs, i_mem.rt, i_wb.rs, i_wb.rt, i_wb.memread};

  always_comb begin
    o_sel = FWD_REG;
    if (!i_ex_valid) begin
      o_sel = FWD_REG;
    end else if (w_mem_hit) begin
      o_sel = FWD_MEM;
    end else if (w_wb_hit) begin
      o_sel = FWD_WB;
    end else begin
      o_sel = FWD_REG;
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for a 5-stage pipeline with a registered EX/MEM/WB shadow.
// Optional build macro HAZARD_STATS_EN adds saturating stall/flush/forward event counters.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int ADDR_W   = SH_ADDR_W,
  parameter bit ZERO_REG = 1'b1,
  parameter bit WB_FWD   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] id_rs_i,
  input  logic [ADDR_W-1:0] id_rt_i,
  input  logic              id_rt_used_i,
  input  logic [ADDR_W-1:0] id_dst_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              redirect_i,
  input  logic              hold_i,
  output logic              stall_o,
  output logic              bubble_o,
  output logic              flush_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stat_stall_o,
  output logic [31:0]       stat_flush_o,
  output logic [31:0]       stat_fwd_o
`endif
);

  stage_sh_t r_ex;
  stage_sh_t r_mem;
  stage_sh_t r_wb;
  stage_sh_t w_id;
  sh_addr_t  w_rs;
  sh_addr_t  w_rt;
  logic      w_luse;

  assign w_rs = sh_addr_t'(id_rs_i);
  assign w_rt = sh_addr_t'(id_rt_i);

  assign w_luse = id_valid_i & is_src(r_ex, ZERO_REG) & r_ex.memread &
                  ((r_ex.dst == w_rs) | (id_rt_used_i & (r_ex.dst == w_rt)));

  // Redirect outranks load-use: the stalled ID instruction is on the wrong path anyway.
  always_comb begin
    stall_o  = 1'b0;
    bubble_o = 1'b0;
    flush_o  = 1'b0;
    if (rst || hold_i) begin
      stall_o  = 1'b0;
      bubble_o = 1'b0;
      flush_o  = 1'b0;
    end else if (redirect_i) begin
      flush_o  = 1'b1;
      bubble_o = 1'b1;
    end else if (w_luse) begin
      stall_o  = 1'b1;
      bubble_o = 1'b1;
    end else begin
      stall_o  = 1'b0;
    end
  end

  always_comb begin
    w_id          = STAGE_CLR;
    w_id.valid    = id_valid_i & ~bubble_o;
    w_id.rs       = w_rs;
    w_id.rt       = w_rt;
    w_id.dst      = sh_addr_t'(id_dst_i);
    w_id.regwrite = id_regwrite_i;
    w_id.memread  = id_memread_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex  <= STAGE_CLR;
      r_mem <= STAGE_CLR;
      r_wb  <= STAGE_CLR;
    end else if (!hold_i) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_id;
    end else begin
      r_wb  <= r_wb;
      r_mem <= r_mem;
      r_ex  <= r_ex;
    end
  end

  fwd_select #(.ZERO_REG(ZERO_REG), .WB_FWD(WB_FWD)) u_fwd_a (
    .i_ex_valid (r_ex.valid),
    .i_src      (r_ex.rs),
    .i_mem      (r_mem),
    .i_wb       (r_wb),
    .o_sel      (fwd_a_o)
  );

  fwd_select #(.ZERO_REG(ZERO_REG), .WB_FWD(WB_FWD)) u_fwd_b (
    .i_ex_valid (r_ex.valid),
    .i_src      (r_ex.rt),
    .i_mem      (r_mem),
    .i_wb       (r_wb),
    .o_sel      (fwd_b_o)
  );

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stat_stall;
  logic [31:0] r_stat_flush;
  logic [31:0] r_stat_fwd;
  logic        w_fwd_any;

  assign w_fwd_any = r_ex.valid & ((fwd_a_o != FWD_REG) | (fwd_b_o != FWD_REG));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_stall <= 32'd0;
      r_stat_flush <= 32'd0;
      r_stat_fwd   <= 32'd0;
    end else if (!hold_i) begin
      r_stat_stall <= sat_inc(r_stat_stall, stall_o);
      r_stat_flush <= sat_inc(r_stat_flush, flush_o);
      r_stat_fwd   <= sat_inc(r_stat_fwd, w_fwd_any);
    end else begin
      r_stat_stall <= r_stat_stall;
      r_stat_flush <= r_stat_flush;
      r_stat_fwd   <= r_stat_fwd;
    end
  end

  assign stat_stall_o = r_stat_stall;
  assign stat_flush_o = r_stat_flush;
  assign stat_fwd_o   = r_stat_fwd;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit; a second instance runs with ZERO_REG=0 on the same inputs.
module tb_pipe_hazard_unit;

  logic       clk;
  logic       rst;
  logic       id_valid_i;
  logic [4:0] id_rs_i;
  logic [4:0] id_rt_i;
  logic       id_rt_used_i;
  logic [4:0] id_dst_i;
  logic       id_regwrite_i;
  logic       id_memread_i;
  logic       redirect_i;
  logic       hold_i;

  logic       stall_o, bubble_o, flush_o;
  logic [1:0] fwd_a_o, fwd_b_o;
  logic       z_stall, z_bubble, z_flush;
  logic [1:0] z_fwd_a, z_fwd_b;
`ifdef HAZARD_STATS_EN
  logic [31:0] stat_stall_o, stat_flush_o, stat_fwd_o;
  logic [31:0] z_stat_stall, z_stat_flush, z_stat_fwd;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  pipe_hazard_unit u_dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_rt_used_i(id_rt_used_i), .id_dst_i(id_dst_i), .id_regwrite_i(id_regwrite_i),
    .id_memread_i(id_memread_i), .redirect_i(redirect_i), .hold_i(hold_i),
    .stall_o(stall_o), .bubble_o(bubble_o), .flush_o(flush_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o)
`ifdef HAZARD_STATS_EN
    , .stat_stall_o(stat_stall_o), .stat_flush_o(stat_flush_o), .stat_fwd_o(stat_fwd_o)
`endif
  );

  pipe_hazard_unit #(.ZERO_REG(1'b0)) u_dut_z0 (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_rt_used_i(id_rt_used_i), .id_dst_i(id_dst_i), .id_regwrite_i(id_regwrite_i),
    .id_memread_i(id_memread_i), .redirect_i(redirect_i), .hold_i(hold_i),
    .stall_o(z_stall), .bubble_o(z_bubble), .flush_o(z_flush),
    .fwd_a_o(z_fwd_a), .fwd_b_o(z_fwd_b)
`ifdef HAZARD_STATS_EN
    , .stat_stall_o(z_stat_stall), .stat_flush_o(z_stat_flush), .stat_fwd_o(z_stat_fwd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, observed running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic rtu, input logic [4:0] dst, input logic rw, input logic mr);
    id_valid_i    = v;
    id_rs_i       = rs;
    id_rt_i       = rt;
    id_rt_used_i  = rtu;
    id_dst_i      = dst;
    id_regwrite_i = rw;
    id_memread_i  = mr;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; hold_i = 1'b0; redirect_i = 1'b1;
    idle();
    #1;
    // Reset: everything low even with a redirect request present
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_bubble", bubble_o, 1'b0);
    chk("rst_flush", flush_o, 1'b0);
    chk("rst_fwd_a", fwd_a_o, 2'b00);
    chk("rst_fwd_b", fwd_b_o, 2'b00);
    redirect_i = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;

    // Load-use: lw r2 then add r3,r2,r4
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
    #1;
    chk("lu_no_stall_empty", stall_o, 1'b0);
    tick();
    set_id(1'b1, 5'd2, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);
    #1;
    chk("lu_stall", stall_o, 1'b1);
    chk("lu_bubble", bubble_o, 1'b1);
    chk("lu_flush", flush_o, 1'b0);
    tick();
    #1;
    chk("lu_stall_once", stall_o, 1'b0);
    chk("lu_bubble_once", bubble_o, 1'b0);
    chk("lu_fwd_a_bubble", fwd_a_o, 2'b00);
    tick();
    idle();
    #1;
    chk("lu_fwd_a_wb", fwd_a_o, 2'b10);
    chk("lu_fwd_b_none", fwd_b_o, 2'b00);
    drain();

    // MEM over WB: add r5; sub r5; and r6,r5,r5
    set_id(1'b1, 5'd1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    chk("prio_no_stall", stall_o, 1'b0);
    tick();
    idle();
    #1;
    chk("prio_fwd_a", fwd_a_o, 2'b01);
    chk("prio_fwd_b", fwd_b_o, 2'b01);
    tick();
    #1;
    chk("prio_ex_empty_fwd_a", fwd_a_o, 2'b00);
    drain();

    // Zero register: load writing r0, consumer reads r0
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0);
    #1;
    chk("zr1_no_stall", stall_o, 1'b0);
    chk("zr0_stall", z_stall, 1'b1);
    chk("zr0_bubble", z_bubble, 1'b1);
    tick();
    #1;
    chk("zr1_fwd_a_mem_load", fwd_a_o, 2'b00);
    tick();
    #1;
    chk("zr1_fwd_a_wb", fwd_a_o, 2'b00);
    chk("zr1_fwd_b_wb", fwd_b_o, 2'b00);
    chk("zr0_fwd_a_wb", z_fwd_a, 2'b10);
    chk("zr0_fwd_b_wb", z_fwd_b, 2'b10);
    drain();

    // Redirect in the same cycle as load-use
    set_id(1'b1, 5'd1, 5'd1, 1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd2, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0);
    redirect_i = 1'b1;
    #1;
    chk("rd_flush", flush_o, 1'b1);
    chk("rd_bubble", bubble_o, 1'b1);
    chk("rd_stall", stall_o, 1'b0);
    tick();
    redirect_i = 1'b0;
    idle();
    #1;
    chk("rd_killed_fwd_a", fwd_a_o, 2'b00);
    chk("rd_killed_fwd_b", fwd_b_o, 2'b00);
    chk("rd_after_stall", stall_o, 1'b0);
    drain();

    // Hold freeze with a MEM forward pending
    set_id(1'b1, 5'd1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0);
    tick();
    hold_i = 1'b1;
    redirect_i = 1'b1;
    set_id(1'b1, 5'd7, 5'd7, 1'b1, 5'd8, 1'b1, 1'b1);
    #1;
    chk("hold_fwd_a", fwd_a_o, 2'b01);
    chk("hold_flush", flush_o, 1'b0);
    chk("hold_bubble", bubble_o, 1'b0);
    chk("hold_stall", stall_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("hold_fwd_a_cyc", fwd_a_o, 2'b01);
      chk("hold_flush_cyc", flush_o, 1'b0);
    end
    hold_i = 1'b0;
    redirect_i = 1'b0;
    idle();
    #1;
    chk("hold_release_fwd_a", fwd_a_o, 2'b01);
    tick();
    #1;
    chk("hold_advanced_fwd_a", fwd_a_o, 2'b00);
    chk("hold_advanced_fwd_b", fwd_b_o, 2'b00);
    drain();

    // Async reset in the middle of a load-use stall
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd2, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);
    #1;
    chk("mrst_pre_stall", stall_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("mrst_stall", stall_o, 1'b0);
    chk("mrst_bubble", bubble_o, 1'b0);
    chk("mrst_fwd_a", fwd_a_o, 2'b00);
`ifdef HAZARD_STATS_EN
    chk("mrst_stat_stall", stat_stall_o, 32'd0);
`endif
    tick();
    rst = 1'b0;
    #1;
    chk("mrst_release_stall", stall_o, 1'b0);
    chk("mrst_release_fwd_a", fwd_a_o, 2'b00);
    drain();

    // Five load-use events, each followed by a WB forward
    for (int k = 0; k < 5; k++) begin
      set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd2, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);
      #1;
      chk("loop_stall", stall_o, 1'b1);
      tick();
      tick();
      #1;
      chk("loop_fwd_a", fwd_a_o, 2'b10);
      idle();
      tick();
    end
`ifdef HAZARD_STATS_EN
    chk("stat_stall_5", stat_stall_o, 32'd5);
    chk("stat_fwd_5", stat_fwd_o, 32'd5);
    chk("stat_flush_0", stat_flush_o, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
